// File: rtl/display7seg_pkg.sv
// Shared definitions for the multi-digit 7-segment display controller:
// per-digit mode encodings, the blank code and the spinner pattern helper.
package display7seg_pkg;

  typedef enum logic [1:0] {
    MODE_HEX   = 2'b00,
    MODE_BLANK = 2'b01,
    MODE_SPIN  = 2'b10,
    MODE_BLINK = 2'b11
  } mode_e;

  // Active-low segment code with every segment dark.
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  // The spinner walks segments a..f; segment g is never part of the loop.
  localparam int SPIN_PHASES = 6;

  // Light only segment <phase>; out-of-range phases give a dark digit.
  function automatic logic [6:0] spin_pattern(input logic [2:0] phase);
    logic [6:0] pat;
    pat = SEG_BLANK;
    if (phase < 3'(SPIN_PHASES)) pat[phase] = 1'b0;
    return pat;
  endfunction

endpackage

// File: rtl/display7seg_if.sv
// Load/display bundle between a datapath block (master) and the
// 7-segment controller (slave).
interface display7seg_if #(
  parameter int N_DIGITS = 6
);
  logic                    load;
  logic [4*N_DIGITS-1:0]   digits;
  logic [2*N_DIGITS-1:0]   mode;
  logic                    lzb;
  logic [7*N_DIGITS-1:0]   displays;
  logic                    anim_tick;

  modport master (
    output load, digits, mode, lzb,
    input  displays, anim_tick
  );

  modport slave (
    input  load, digits, mode, lzb,
    output displays, anim_tick
  );
endinterface

// File: rtl/seg7_decode.sv
// Combinational hex font: 4-bit value to active-low segments {g,f,e,d,c,b,a}.
module seg7_decode (
  input  logic [3:0] digit_i,
  output logic [6:0] seg_o
);

  // Standard 0-F font, lower-case b and d to keep them distinct from 8 and 0.
  always_comb begin
    // NOTE: every path assigns seg_o (the default arm included), so no latch is inferred.
    unique case (digit_i)
      4'h0:    seg_o = 7'b1000000;
      4'h1:    seg_o = 7'b1111001;
      4'h2:    seg_o = 7'b0100100;
      4'h3:    seg_o = 7'b0110000;
      4'h4:    seg_o = 7'b0011001;
      4'h5:    seg_o = 7'b0010010;
      4'h6:    seg_o = 7'b0000010;
      4'h7:    seg_o = 7'b1111000;
      4'h8:    seg_o = 7'b0000000;
      4'h9:    seg_o = 7'b0010000;
      4'hA:    seg_o = 7'b0001000;
      4'hB:    seg_o = 7'b0000011;
      4'hC:    seg_o = 7'b1000110;
      4'hD:    seg_o = 7'b0100001;
      4'hE:    seg_o = 7'b0000110;
      default: seg_o = 7'b0001110;
    endcase
  end

endmodule

// File: rtl/display7seg_controller.sv
// Multi-digit 7-segment controller: holding registers loaded by strobe,
// free-running spinner/blink timers, leading-zero blanking and a
// registered per-digit mode mux driving active-low segment codes.
module display7seg_controller
  import display7seg_pkg::*;
#(
  parameter int N_DIGITS  = 6,
  parameter int ANIM_DIV  = 12_500_000,
  parameter int BLINK_DIV = 25_000_000
) (
  input  logic         clock_i,
  input  logic         reset_i,
  display7seg_if.slave bus
);

  localparam int AW = (ANIM_DIV  > 1) ? $clog2(ANIM_DIV)  : 1;
  localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam logic [AW-1:0] ANIM_LAST  = AW'(ANIM_DIV - 1);
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_DIV - 1);

  logic [4*N_DIGITS-1:0] val_q;
  logic [2*N_DIGITS-1:0] mode_q;
  logic                  lzb_q;

  logic [AW-1:0] anim_cnt_q,  anim_cnt_d;
  logic [BW-1:0] blink_cnt_q, blink_cnt_d;
  logic [2:0]    phase_q,     phase_d;
  logic          blink_on_q,  blink_on_d;
  logic          anim_wrap,   blink_wrap;

  logic [7*N_DIGITS-1:0] hex_seg;
  logic [N_DIGITS-1:0]   lz_blank;
  logic                  zero_run;
  logic [7*N_DIGITS-1:0] disp_q, disp_d;
  logic                  tick_q;

  // Holding registers capture the datapath's request on the load strobe.
  always_ff @(posedge clock_i) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (reset_i) begin
      val_q  <= '0;
      mode_q <= {N_DIGITS{MODE_BLANK}};
      lzb_q  <= 1'b0;
    end else if (bus.load) begin
      val_q  <= bus.digits;
      mode_q <= bus.mode;
      lzb_q  <= bus.lzb;
    end
  end

  // Next state of the free-running prescalers, spinner phase and blink flag.
  always_comb begin
    anim_wrap   = (anim_cnt_q == ANIM_LAST);
    blink_wrap  = (blink_cnt_q == BLINK_LAST);
    anim_cnt_d  = anim_wrap  ? '0 : anim_cnt_q + 1'b1;
    blink_cnt_d = blink_wrap ? '0 : blink_cnt_q + 1'b1;
    phase_d     = phase_q;
    if (anim_wrap)
      phase_d = (phase_q == 3'(SPIN_PHASES - 1)) ? 3'd0 : phase_q + 3'd1;
    blink_on_d  = blink_wrap ? ~blink_on_q : blink_on_q;
  end

  // Timer state register; load deliberately leaves it untouched.
  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      anim_cnt_q  <= '0;
      blink_cnt_q <= '0;
      phase_q     <= 3'd0;
      blink_on_q  <= 1'b1;
    end else begin
      anim_cnt_q  <= anim_cnt_d;
      blink_cnt_q <= blink_cnt_d;
      phase_q     <= phase_d;
      blink_on_q  <= blink_on_d;
    end
  end

  for (genvar g = 0; g < N_DIGITS; g++) begin : g_dec
    seg7_decode u_dec (
      .digit_i (val_q[4*g +: 4]),
      .seg_o   (hex_seg[7*g +: 7])
    );
  end

  // Leading-zero scan from the top digit down; any non-hex or non-zero digit ends the run.
  always_comb begin
    zero_run = 1'b1;
    lz_blank = '0;
    for (int i = N_DIGITS - 1; i >= 1; i--) begin
      zero_run    = zero_run && (mode_q[2*i +: 2] == MODE_HEX) && (val_q[4*i +: 4] == 4'h0);
      lz_blank[i] = lzb_q && zero_run;
    end
  end

  // Per-digit mode mux selecting hex, blank, spinner or blinking hex.
  always_comb begin
    disp_d = '1;
    for (int i = 0; i < N_DIGITS; i++) begin
      case (mode_q[2*i +: 2])
        MODE_HEX:   disp_d[7*i +: 7] = lz_blank[i] ? SEG_BLANK : hex_seg[7*i +: 7];
        MODE_SPIN:  disp_d[7*i +: 7] = spin_pattern(phase_q);
        MODE_BLINK: disp_d[7*i +: 7] = blink_on_q ? hex_seg[7*i +: 7] : SEG_BLANK;
        default:    disp_d[7*i +: 7] = SEG_BLANK;
      endcase
    end
  end

  // Output register: segments and the phase-advance pulse come straight from flops.
  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      disp_q <= '1;
      tick_q <= 1'b0;
    end else begin
      disp_q <= disp_d;
      tick_q <= anim_wrap;
    end
  end

  assign bus.displays  = disp_q;
  assign bus.anim_tick = tick_q;

endmodule

// File: tb/tb_display7seg_controller.sv
// Directed bench for display7seg_controller with N_DIGITS=4, ANIM_DIV=2, BLINK_DIV=4.
module tb_display7seg_controller;

  localparam int N  = 4;
  localparam int AD = 2;
  localparam int BD = 4;

  logic clk;
  logic rst;
  int   checks;
  int   passed;
  int   cyc;   // non-reset edges since the last reset edge

  display7seg_if #(.N_DIGITS(N)) bus ();

  display7seg_controller #(
    .N_DIGITS  (N),
    .ANIM_DIV  (AD),
    .BLINK_DIV (BD)
  ) dut (
    .clock_i (clk),
    .reset_i (rst),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (rst) cyc <= 0;
    else     cyc <= cyc + 1;
  end

  function automatic logic [6:0] dig(input int i);
    return bus.displays[7*i +: 7];
  endfunction

  // Present one load strobe at the current negedge; returns just after the capturing edge.
  task automatic do_load(input logic [15:0] d, input logic [7:0] m, input logic l);
    bus.digits = d;
    bus.mode   = m;
    bus.lzb    = l;
    bus.load   = 1'b1;
    @(negedge clk);
    bus.load   = 1'b0;
  endtask

  task automatic test_reset();
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      checks++;
      if (bus.displays !== 28'hFFFFFFF || bus.anim_tick !== 1'b0)
        $display("FAIL reset_hold cyc%0d: displays=%h tick=%b, want FFFFFFF/0", c, bus.displays, bus.anim_tick);
      else passed++;
    end
    rst = 1'b0;
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      checks++;
      if (bus.displays !== 28'hFFFFFFF)
        $display("FAIL reset_release edge%0d: displays=%h, want FFFFFFF", c, bus.displays);
      else passed++;
      if (c <= 2) begin
        checks++;
        if (bus.anim_tick !== (c == 2))
          $display("FAIL first_tick edge%0d: tick=%b, want %b", c, bus.anim_tick, (c == 2));
        else passed++;
      end
    end
  endtask

  task automatic test_hex();
    logic [15:0] dv [5];
    logic [27:0] ev [5];
    dv = '{16'h12AF, 16'h3210, 16'h7654, 16'hBA98, 16'hFEDC};
    ev = '{{7'h79, 7'h24, 7'h08, 7'h0E},
           {7'h30, 7'h24, 7'h79, 7'h40},
           {7'h78, 7'h02, 7'h12, 7'h19},
           {7'h03, 7'h08, 7'h10, 7'h00},
           {7'h0E, 7'h06, 7'h21, 7'h46}};
    for (int v = 0; v < 5; v++) begin
      do_load(dv[v], 8'h00, 1'b0);
      checks++;
      if (v > 0 && bus.displays === ev[v])
        $display("FAIL hex_latency %h: displays=%h already updated, want previous value", dv[v], bus.displays);
      else passed++;
      @(negedge clk);
      checks++;
      if (bus.displays !== ev[v])
        $display("FAIL hex %h: displays=%h, want %h", dv[v], bus.displays, ev[v]);
      else passed++;
    end
  endtask

  task automatic test_lzb();
    logic [15:0] dv [5];
    logic [7:0]  mv [5];
    logic        lv [5];
    logic [27:0] ev [5];
    dv = '{16'h0500, 16'h0050, 16'h0000, 16'h0000, 16'h0000};
    mv = '{8'h00,    8'h00,    8'h00,    8'h40,    8'h00};
    lv = '{1'b1,     1'b1,     1'b1,     1'b1,     1'b0};
    ev = '{{7'h7F, 7'h12, 7'h40, 7'h40},
           {7'h7F, 7'h7F, 7'h12, 7'h40},
           {7'h7F, 7'h7F, 7'h7F, 7'h40},
           {7'h7F, 7'h40, 7'h40, 7'h40},
           {7'h40, 7'h40, 7'h40, 7'h40}};
    for (int v = 0; v < 5; v++) begin
      do_load(dv[v], mv[v], lv[v]);
      @(negedge clk);
      checks++;
      if (bus.displays !== ev[v])
        $display("FAIL lzb %h/%h/%b: displays=%h, want %h", dv[v], mv[v], lv[v], bus.displays, ev[v]);
      else passed++;
    end
  endtask

  task automatic test_spinner();
    logic [6:0] pat [7];
    int ticks;
    pat = '{7'h7E, 7'h7D, 7'h7B, 7'h77, 7'h6F, 7'h5F, 7'h7E};
    for (int w = 0; w < 16 && (cyc % 12) != 11; w++) @(negedge clk);
    do_load(16'h0000, 8'h56, 1'b0);
    ticks = 0;
    for (int k = 2; k <= 15; k++) begin
      @(negedge clk);
      checks++;
      if (dig(0) !== pat[(k-2)/2] || dig(1) !== 7'h7F)
        $display("FAIL spin step%0d: digit0=%b digit1=%b, want %b/1111111", k, dig(0), dig(1), pat[(k-2)/2]);
      else passed++;
      checks++;
      if (bus.anim_tick !== (k % 2 == 1))
        $display("FAIL spin_tick step%0d: tick=%b, want %b", k, bus.anim_tick, (k % 2 == 1));
      else passed++;
      if (k <= 13 && bus.anim_tick === 1'b1) ticks++;
    end
    checks++;
    if (ticks != 6)
      $display("FAIL spin_rev_ticks: got %0d, want 6", ticks);
    else passed++;
  endtask

  task automatic test_blink();
    logic [6:0] ex;
    do_load(16'h0080, 8'h5D, 1'b0);
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      ex = ((((cyc - 1) / 4) % 2) == 0) ? 7'h00 : 7'h7F;
      checks++;
      if (dig(1) !== ex || dig(0) !== 7'h7F || dig(2) !== 7'h7F)
        $display("FAIL blink cyc%0d: digit1=%b digit0=%b digit2=%b, want %b/1111111/1111111",
                 cyc, dig(1), dig(0), dig(2), ex);
      else passed++;
    end
  endtask

  task automatic test_blink_same_edge();
    for (int w = 0; w < 16 && (cyc % 8) != 3; w++) @(negedge clk);
    do_load(16'h0037, 8'h5C, 1'b0);
    checks++;
    if (dig(1) !== 7'h00 || dig(0) !== 7'h7F)
      $display("FAIL blink_edge_before: digit1=%b digit0=%b, want 0000000/1111111", dig(1), dig(0));
    else passed++;
    @(negedge clk);
    checks++;
    if (dig(1) !== 7'h7F || dig(0) !== 7'h78)
      $display("FAIL blink_edge_after: digit1=%b digit0=%b, want 1111111/1111000", dig(1), dig(0));
    else passed++;
    repeat (3) @(negedge clk);
    checks++;
    if (dig(1) !== 7'h7F)
      $display("FAIL blink_edge_off: digit1=%b, want 1111111", dig(1));
    else passed++;
    @(negedge clk);
    checks++;
    if (dig(1) !== 7'h30)
      $display("FAIL blink_edge_on: digit1=%b, want 0110000", dig(1));
    else passed++;
  endtask

  task automatic test_reset_during_load();
    rst        = 1'b1;
    bus.load   = 1'b1;
    bus.digits = 16'hFFFF;
    bus.mode   = 8'h00;
    bus.lzb    = 1'b0;
    @(negedge clk);
    rst      = 1'b0;
    bus.load = 1'b0;
    checks++;
    if (bus.displays !== 28'hFFFFFFF || bus.anim_tick !== 1'b0)
      $display("FAIL rst_load_now: displays=%h tick=%b, want FFFFFFF/0", bus.displays, bus.anim_tick);
    else passed++;
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      checks++;
      if (bus.displays !== 28'hFFFFFFF)
        $display("FAIL rst_load_hold edge%0d: displays=%h, want FFFFFFF", c, bus.displays);
      else passed++;
    end
  endtask

  initial begin
    checks     = 0;
    passed     = 0;
    rst        = 1'b1;
    bus.load   = 1'b0;
    bus.digits = '0;
    bus.mode   = '0;
    bus.lzb    = 1'b0;
    test_reset();
    test_hex();
    test_lzb();
    test_spinner();
    test_blink();
    test_blink_same_edge();
    test_reset_during_load();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete, want completion");
    $fatal(1);
  end

endmodule
